// File: rtl/tile_map_pkg.sv
// Shared tile-map definitions for the tile mover and the renderer:
// cell codes, default grid size, map word layout and the mover FSM encoding.
package tile_map_pkg;

    localparam logic [3:0] CELL_WALL   = 4'd0;
    localparam logic [3:0] CELL_FLOOR  = 4'd1;
    localparam logic [3:0] CELL_PLAYER = 4'd2;

    localparam int GRID_W_DEF    = 20;
    localparam int GRID_H_DEF    = 15;
    localparam int WORDS_PER_ROW = 5;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int X_W    = 5;
    localparam int Y_W    = 4;
    localparam int CNT_W  = 7;

    localparam logic [CNT_W-1:0] MOVE_COUNT_MAX = 7'd99;

    typedef enum logic [3:0] {
        PL_RD,
        PL_CHK,
        PL_WR,
        IDLE,
        RD_NEW,
        CHK_NEW,
        WR_NEW,
        RD_OLD,
        CHK_OLD,
        WR_OLD
    } mover_state_t;

    // Four cells per word, so the word address is row*5 + column/4.
    function automatic logic [ADDR_W-1:0] cellAddr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] rowBase;
        rowBase = {7'd0, y} * ADDR_W'(WORDS_PER_ROW);
        return rowBase + {8'd0, x[4:2]};
    endfunction

    function automatic logic [3:0] getNibble(input logic [DATA_W-1:0] word,
                                             input logic [1:0]        idx);
        return word[idx*4 +: 4];
    endfunction

    function automatic logic [DATA_W-1:0] setNibble(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        idx,
                                                    input logic [3:0]        val);
        logic [DATA_W-1:0] result;
        result = word;
        result[idx*4 +: 4] = val;
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Button conditioner: 2-flop synchronizer, optional stability filter and
// rising-edge detector producing a one-cycle press pulse.
// Build option: MOVER_DEBOUNCE_EN enables the DEBOUNCE_CYCLES stability filter;
// without it the press is taken straight from the synchronizer.
module switch_debounce
    import tile_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
)(
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Press
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
        end
    end

`ifdef MOVER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] count_q;
    logic [DB_W-1:0] count_d;
    logic            stable_q;
    logic            stable_d;

    // Accept a new level only once it has differed from the accepted one long enough
    always_comb begin
        stable_d = stable_q;
        count_d  = '0;
        if (sync2_q != stable_q) begin
            if (count_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Hold the filter state
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            stable_q <= stable_d;
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    // Remember the previous conditioned level for edge detection
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign o_Press = level & ~prev_q;

endmodule

// File: rtl/tile_mover.sv
// Tile mover: moves a player marker around a nibble-packed tile map held in
// an external single-port BRAM, one cell per button press.
// Build option: MOVER_DEBOUNCE_EN adds button debouncing in switch_debounce.
module tile_mover
    import tile_map_pkg::*;
#(
    parameter int GRID_W          = GRID_W_DEF,
    parameter int GRID_H          = GRID_H_DEF,
    parameter int START_X         = 0,
    parameter int START_Y         = 0,
    parameter int DEBOUNCE_CYCLES = 250000
)(
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Switch_1,
    input  logic              i_Switch_2,
    input  logic              i_Switch_3,
    input  logic              i_Switch_4,
    input  logic [DATA_W-1:0] i_Bram_RData,
    output logic [ADDR_W-1:0] o_Bram_Addr,
    output logic [DATA_W-1:0] o_Bram_WData,
    output logic              o_Bram_WE,
    output logic [X_W-1:0]    o_Player_X,
    output logic [Y_W-1:0]    o_Player_Y,
    output logic              o_Busy,
    output logic [CNT_W-1:0]  o_Move_Count
);

    localparam logic [X_W-1:0] START_X_L = X_W'(START_X);
    localparam logic [Y_W-1:0] START_Y_L = Y_W'(START_Y);

    logic pressUp;
    logic pressDown;
    logic pressLeft;
    logic pressRight;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swUp (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_1), .o_Press(pressUp)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swDown (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_2), .o_Press(pressDown)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swLeft (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_3), .o_Press(pressLeft)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swRight (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_4), .o_Press(pressRight)
    );

    mover_state_t      state_q;
    mover_state_t      state_d;
    logic [X_W-1:0]    playerX_q;
    logic [X_W-1:0]    playerX_d;
    logic [Y_W-1:0]    playerY_q;
    logic [Y_W-1:0]    playerY_d;
    logic [X_W-1:0]    targetX_q;
    logic [X_W-1:0]    targetX_d;
    logic [Y_W-1:0]    targetY_q;
    logic [Y_W-1:0]    targetY_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [CNT_W-1:0]  moveCount_q;
    logic [CNT_W-1:0]  moveCount_d;

    logic              moveValid;
    logic [X_W-1:0]    candX;
    logic [Y_W-1:0]    candY;

    // Pick the highest-priority press and decide whether its target is on the grid
    always_comb begin
        candX     = playerX_q;
        candY     = playerY_q;
        moveValid = 1'b0;
        if (pressUp) begin
            if (playerY_q != '0) begin
                candY     = playerY_q - 1'b1;
                moveValid = 1'b1;
            end
        end else if (pressDown) begin
            if (int'(playerY_q) < GRID_H - 1) begin
                candY     = playerY_q + 1'b1;
                moveValid = 1'b1;
            end
        end else if (pressLeft) begin
            if (playerX_q != '0) begin
                candX     = playerX_q - 1'b1;
                moveValid = 1'b1;
            end
        end else if (pressRight) begin
            if (int'(playerX_q) < GRID_W - 1) begin
                candX     = playerX_q + 1'b1;
                moveValid = 1'b1;
            end
        end
    end

    // State and datapath registers; reset parks the FSM ready to place the player
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= PL_RD;
            playerX_q   <= START_X_L;
            playerY_q   <= START_Y_L;
            targetX_q   <= START_X_L;
            targetY_q   <= START_Y_L;
            wdata_q     <= '0;
            moveCount_q <= '0;
        end else begin
            state_q     <= state_d;
            playerX_q   <= playerX_d;
            playerY_q   <= playerY_d;
            targetX_q   <= targetX_d;
            targetY_q   <= targetY_d;
            wdata_q     <= wdata_d;
            moveCount_q <= moveCount_d;
        end
    end

    // Next-state sequencing; a wall in the target cell ends the move early
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PL_RD:   state_d = PL_CHK;
            PL_CHK:  state_d = PL_WR;
            PL_WR:   state_d = IDLE;
            IDLE:    if (moveValid) state_d = RD_NEW;
            RD_NEW:  state_d = CHK_NEW;
            CHK_NEW: state_d = (getNibble(i_Bram_RData, targetX_q[1:0]) == CELL_WALL)
                               ? IDLE : WR_NEW;
            WR_NEW:  state_d = RD_OLD;
            RD_OLD:  state_d = CHK_OLD;
            CHK_OLD: state_d = WR_OLD;
            WR_OLD:  state_d = IDLE;
            default: state_d = PL_RD;
        endcase
    end

    // Datapath updates: latch target, build the read-modify-write words, commit the move
    always_comb begin
        playerX_d   = playerX_q;
        playerY_d   = playerY_q;
        targetX_d   = targetX_q;
        targetY_d   = targetY_q;
        wdata_d     = wdata_q;
        moveCount_d = moveCount_q;
        case (state_q)
            PL_CHK:  wdata_d = setNibble(i_Bram_RData, START_X_L[1:0], CELL_PLAYER);
            IDLE: begin
                if (moveValid) begin
                    targetX_d = candX;
                    targetY_d = candY;
                end
            end
            CHK_NEW: wdata_d = setNibble(i_Bram_RData, targetX_q[1:0], CELL_PLAYER);
            CHK_OLD: wdata_d = setNibble(i_Bram_RData, playerX_q[1:0], CELL_FLOOR);
            WR_OLD: begin
                playerX_d   = targetX_q;
                playerY_d   = targetY_q;
                moveCount_d = (moveCount_q == MOVE_COUNT_MAX)
                              ? MOVE_COUNT_MAX : moveCount_q + 1'b1;
            end
            default: ;
        endcase
    end

    // BRAM port and status outputs; the address is forced to zero while in reset
    always_comb begin
        o_Bram_Addr = '0;
        o_Bram_WE   = 1'b0;
        if (i_Rst_L) begin
            case (state_q)
                PL_RD, PL_CHK, PL_WR:     o_Bram_Addr = cellAddr(START_X_L, START_Y_L);
                RD_NEW, CHK_NEW, WR_NEW:  o_Bram_Addr = cellAddr(targetX_q, targetY_q);
                RD_OLD, CHK_OLD, WR_OLD:  o_Bram_Addr = cellAddr(playerX_q, playerY_q);
                default:                  o_Bram_Addr = '0;
            endcase
            o_Bram_WE = (state_q == PL_WR) || (state_q == WR_NEW) || (state_q == WR_OLD);
        end
    end

    assign o_Bram_WData = wdata_q;
    assign o_Busy       = (state_q != IDLE);
    assign o_Player_X   = playerX_q;
    assign o_Player_Y   = playerY_q;
    assign o_Move_Count = moveCount_q;

endmodule

// File: tb/tb_tile_mover.sv
// Testbench for tile_mover: behavioural BRAM, a scoreboard of expected
// writes filled by a map model at press time and drained by a write monitor.
module tb_tile_mover;

   localparam int GW = 20;
   localparam int GH = 15;

   logic        clock = 1'b0;
   logic        rstL;
   logic        sw1, sw2, sw3, sw4;
   logic [15:0] bramRData;
   logic [10:0] bramAddr;
   logic [15:0] bramWData;
   logic        bramWE;
   logic [4:0]  playerX;
   logic [3:0]  playerY;
   logic        busy;
   logic [6:0]  moveCount;

   tile_mover dut (
      .i_Clk(clock),
      .i_Rst_L(rstL),
      .i_Switch_1(sw1),
      .i_Switch_2(sw2),
      .i_Switch_3(sw3),
      .i_Switch_4(sw4),
      .i_Bram_RData(bramRData),
      .o_Bram_Addr(bramAddr),
      .o_Bram_WData(bramWData),
      .o_Bram_WE(bramWE),
      .o_Player_X(playerX),
      .o_Player_Y(playerY),
      .o_Busy(busy),
      .o_Move_Count(moveCount)
   );

   // Free-running clock
   always #5 clock = ~clock;

   logic [15:0] mem [0:127];
   logic        tbWe = 1'b0;
   logic [6:0]  tbAddr = '0;
   logic [15:0] tbData = '0;

   // Single-port BRAM with one-cycle read latency and a bench back-door write port
   always @(posedge clock) begin
      bramRData <= mem[bramAddr[6:0]];
      if (bramWE)
         mem[bramAddr[6:0]] <= bramWData;
      else if (tbWe)
         mem[tbAddr] <= tbData;
   end

   typedef struct {
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         expQ[$];
   wr_t         popped;
   logic [15:0] modelMap [0:127];
   int          expX, expY, expCount;
   int          errors = 0;
   int          checks = 0;
   int          busyTotal = 0;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Count busy cycles and match every DUT write against the scoreboard
   always @(negedge clock) begin
      if (busy === 1'b1) busyTotal++;
      if (bramWE === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("writesPending", 32'(expQ.size()), 32'd1);
         end else begin
            popped = expQ.pop_front();
            checkOutput("writeAddr", 32'(bramAddr), 32'(popped.addr));
            checkOutput("writeData", 32'(bramWData), 32'(popped.data));
         end
      end
   end

   function automatic int wordAddr(input int x, input int y);
      return y * 5 + x / 4;
   endfunction

   function automatic logic [15:0] setNib(input logic [15:0] w, input int idx, input logic [3:0] v);
      logic [15:0] r;
      r = w;
      r[idx*4 +: 4] = v;
      return r;
   endfunction

   function automatic logic [3:0] getNib(input logic [15:0] w, input int idx);
      return w[idx*4 +: 4];
   endfunction

   task automatic pushWrite(input int a, input logic [15:0] d);
      wr_t e;
      e.addr = 11'(a);
      e.data = d;
      expQ.push_back(e);
   endtask

   // Predict one press: 0 up, 1 down, 2 left, 3 right; returns expected busy cycles
   task automatic modelMove(input int dir, output int expBusy);
      int tx, ty, na, oa;
      bit ok;
      tx = expX; ty = expY; ok = 0;
      case (dir)
         0: if (ty > 0)      begin ty--; ok = 1; end
         1: if (ty < GH - 1) begin ty++; ok = 1; end
         2: if (tx > 0)      begin tx--; ok = 1; end
         default: if (tx < GW - 1) begin tx++; ok = 1; end
      endcase
      if (!ok) begin
         expBusy = 0;
      end else begin
         na = wordAddr(tx, ty);
         if (getNib(modelMap[na], tx % 4) == 4'd0) begin
            expBusy = 2;
         end else begin
            modelMap[na] = setNib(modelMap[na], tx % 4, 4'd2);
            pushWrite(na, modelMap[na]);
            oa = wordAddr(expX, expY);
            modelMap[oa] = setNib(modelMap[oa], expX % 4, 4'd1);
            pushWrite(oa, modelMap[oa]);
            expX = tx;
            expY = ty;
            if (expCount < 99) expCount++;
            expBusy = 6;
         end
      end
   endtask

   // Press bits {right,left,down,up}; lateSw is raised mid-move and held to the end
   task automatic applyStimulus(input logic [3:0] sw, input logic [3:0] lateSw, input string tag);
      int winner, expBusy, b0;
      logic [3:0] cur;
      winner = 3;
      for (int i = 3; i >= 0; i--) if (sw[i]) winner = i;
      modelMove(winner, expBusy);
      @(posedge clock);
      b0 = busyTotal;
      @(negedge clock);
      cur = sw;
      {sw4, sw3, sw2, sw1} = cur;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clock);
         if (i == 3) cur = 4'b0000;
         if (i == 5) cur = lateSw;
         {sw4, sw3, sw2, sw1} = cur;
      end
      {sw4, sw3, sw2, sw1} = 4'b0000;
      repeat (4) @(negedge clock);
      checkOutput({tag, ".busyCycles"}, 32'(busyTotal - b0), 32'(expBusy));
      checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
      checkOutput({tag, ".playerX"}, 32'(playerX), 32'(expX));
      checkOutput({tag, ".playerY"}, 32'(playerY), 32'(expY));
      checkOutput({tag, ".moveCount"}, 32'(moveCount), 32'(expCount));
      checkOutput({tag, ".writesLeft"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic setCell(input int x, input int y, input logic [3:0] v);
      int a;
      a = wordAddr(x, y);
      modelMap[a] = setNib(modelMap[a], x % 4, v);
      @(negedge clock);
      tbWe = 1'b1; tbAddr = 7'(a); tbData = modelMap[a];
      @(negedge clock);
      tbWe = 1'b0;
   endtask

   localparam logic [3:0] UP    = 4'b0001;
   localparam logic [3:0] DOWN  = 4'b0010;
   localparam logic [3:0] LEFT  = 4'b0100;
   localparam logic [3:0] RIGHT = 4'b1000;
   localparam logic [3:0] NONE  = 4'b0000;

   initial begin
      int b0;
      rstL = 1'b0;
      {sw4, sw3, sw2, sw1} = 4'b0000;
      expX = 0; expY = 0; expCount = 0;

      for (int a = 0; a < 128; a++) begin
         @(negedge clock);
         tbWe = 1'b1; tbAddr = 7'(a); tbData = 16'h1111;
         modelMap[a] = 16'h1111;
      end
      @(negedge clock);
      tbWe = 1'b0;
      @(negedge clock);

      checkOutput("reset.we", 32'(bramWE), 32'd0);
      checkOutput("reset.addr", 32'(bramAddr), 32'd0);
      checkOutput("reset.wdata", 32'(bramWData), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd1);
      checkOutput("reset.playerX", 32'(playerX), 32'd0);
      checkOutput("reset.playerY", 32'(playerY), 32'd0);
      checkOutput("reset.moveCount", 32'(moveCount), 32'd0);

      modelMap[0] = 16'h1112;
      pushWrite(0, 16'h1112);
      @(posedge clock);
      b0 = busyTotal;
      @(negedge clock);
      rstL = 1'b1;
      repeat (8) @(negedge clock);
      checkOutput("place.busyCycles", 32'(busyTotal - b0), 32'd3);
      checkOutput("place.writesLeft", 32'(expQ.size()), 32'd0);
      expQ.delete();

      applyStimulus(LEFT, NONE, "leftAtEdge");
      applyStimulus(UP, NONE, "upAtEdge");
      applyStimulus(DOWN, NONE, "down");
      applyStimulus(UP, NONE, "upBack");
      applyStimulus(RIGHT, NONE, "right1");
      applyStimulus(RIGHT, NONE, "right2");
      applyStimulus(RIGHT, NONE, "right3");
      applyStimulus(RIGHT, NONE, "rightCrossWord");

      setCell(5, 0, 4'd0);
      applyStimulus(RIGHT, NONE, "wall");
      applyStimulus(DOWN, NONE, "downAtX4");
      applyStimulus(UP | RIGHT, LEFT, "priorityAndDrop");
      setCell(5, 0, 4'd1);

      for (int i = 0; i < 15; i++) applyStimulus(RIGHT, NONE, "sweepRight");
      applyStimulus(RIGHT, NONE, "rightAtEdge");
      for (int i = 0; i < 14; i++) applyStimulus(DOWN, NONE, "sweepDown");
      applyStimulus(DOWN, NONE, "downAtEdge");
      for (int i = 0; i < 70; i++)
         applyStimulus((i % 2 == 0) ? LEFT : RIGHT, NONE, "saturate");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
